// File: rtl/probe_bank_pkg.sv
// Shared constants for the probe bank: register offsets, CTRL bit positions
// and the words-per-probe helper used to size the register map.
package probe_bank_pkg;

  localparam int CTRL_OFF       = 0;
  localparam int CHANGE_OFF     = 1;
  localparam int FIRST_SNAP_OFF = 2;

  localparam int SNAP_BIT    = 0;
  localparam int COMMIT_BIT  = 1;
  localparam int PENDING_BIT = 1;

  // Number of 16-bit bus words needed to hold one probe of the given width.
  function automatic int words_for(input int width);
    return (width + 15) / 16;
  endfunction

endpackage

// File: rtl/probe_bank_if.sv
// Upstream/downstream bus pair that the probe bank sits in the middle of.
//
// Handshake: valid_i qualifies a single-cycle transaction (rw_i=1 write,
// rw_i=0 read). There is no ready; the block accepts every cycle. Every
// field reappears on its _o twin exactly one cycle later, with valid_o
// qualifying that registered copy the same way.
interface probe_bank_if;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_i;
  logic        rw_i;
  logic        valid_i;

  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic [15:0] rdata_o;
  logic        rw_o;
  logic        valid_o;

  modport slave (
    input  addr_i, wdata_i, rdata_i, rw_i, valid_i,
    output addr_o, wdata_o, rdata_o, rw_o, valid_o
  );

  modport master (
    output addr_i, wdata_i, rdata_i, rw_i, valid_i,
    input  addr_o, wdata_o, rdata_o, rw_o, valid_o
  );
endinterface

// File: rtl/probe_bank_change.sv
// Per-probe change detector: remembers last cycle's probe value and keeps a
// sticky flag per probe. A clear and a fresh change on the same edge leave
// the flag set, so no change is ever lost.
module probe_bank_change #(
  parameter int N_IN     = 4,
  parameter int IN_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN*IN_WIDTH-1:0] probes_in,
  input  logic                     clr_i,
  output logic [N_IN-1:0]          flags_o
);

  logic [N_IN*IN_WIDTH-1:0] prev_q, prev_d;
  logic [N_IN-1:0]          flags_q, flags_d;

  // Next flags: set on any difference from the previous sample, else hold unless cleared.
  always_comb begin
    prev_d  = probes_in;
    flags_d = flags_q;
    for (int i = 0; i < N_IN; i++) begin
      flags_d[i] = (probes_in[i*IN_WIDTH +: IN_WIDTH] != prev_q[i*IN_WIDTH +: IN_WIDTH])
                   | (flags_q[i] & ~clr_i);
    end
  end

  // Previous-sample and flag registers; reset makes the first sample compare against zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      flags_q <= '0;
    end else begin
      prev_q  <= prev_d;
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/probe_bank.sv
// Bus-mapped probe bank: snapshots input probes, stages and commits output
// probes, and flags input changes, all while passing the bus through with
// one cycle of latency.
module probe_bank
  import probe_bank_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int N_IN      = 4,
  parameter int IN_WIDTH  = 20,
  parameter int N_OUT     = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*IN_WIDTH-1:0]   probes_in,
  output logic [N_OUT*OUT_WIDTH-1:0] probes_out,
  probe_bank_if.slave                bus
);

  localparam int IN_WORDS   = words_for(IN_WIDTH);
  localparam int OUT_WORDS  = words_for(OUT_WIDTH);
  localparam int SNAP_WORDS = N_IN * IN_WORDS;
  localparam int STG_WORDS  = N_OUT * OUT_WORDS;
  localparam int STG_OFF    = FIRST_SNAP_OFF + SNAP_WORDS;
  localparam int LAST_OFF   = STG_OFF + STG_WORDS - 1;

  localparam logic [15:0] BASE16 = 16'(BASE_ADDR);
  localparam logic [16:0] LAST17 = 17'(LAST_OFF);

  // Snapshot and staging storage are kept word-padded so every register
  // word is a plain 16-bit slice; padding bits are only ever written as 0.
  logic [SNAP_WORDS*16-1:0]    snap_q, snap_d;
  logic [STG_WORDS*16-1:0]     stg_q, stg_d;
  logic [N_OUT*OUT_WIDTH-1:0]  out_q, out_d;
  logic                        pending_q, pending_d;

  logic [15:0] addr_o_q, addr_o_d;
  logic [15:0] wdata_o_q, wdata_o_d;
  logic [15:0] rdata_o_q, rdata_o_d;
  logic        rw_o_q, rw_o_d;
  logic        valid_o_q, valid_o_d;

  logic [16:0]     off17;
  logic            hit;
  logic            wr_hit;
  logic            rd_hit;
  logic            snap;
  logic            commit;
  logic [15:0]     rd_word;
  logic [N_IN-1:0] change_flags;

  // Address decode and CTRL strobes for the current bus transaction.
  always_comb begin
    off17  = {1'b0, bus.addr_i} - {1'b0, BASE16};
    hit    = bus.valid_i && (bus.addr_i >= BASE16) && (off17 <= LAST17);
    wr_hit = hit && bus.rw_i;
    rd_hit = hit && !bus.rw_i;
    snap   = wr_hit && (off17 == 17'(CTRL_OFF)) && bus.wdata_i[SNAP_BIT];
    commit = wr_hit && (off17 == 17'(CTRL_OFF)) && bus.wdata_i[COMMIT_BIT];
  end

  probe_bank_change #(
    .N_IN     (N_IN),
    .IN_WIDTH (IN_WIDTH)
  ) u_change (
    .clk       (clk),
    .rst       (rst),
    .probes_in (probes_in),
    .clr_i     (snap),
    .flags_o   (change_flags)
  );

  // Next register state: snapshot capture, commit to outputs, staging writes.
  always_comb begin
    snap_d    = snap_q;
    stg_d     = stg_q;
    out_d     = out_q;
    pending_d = pending_q;
    if (snap) begin
      snap_d = '0;
      for (int p = 0; p < N_IN; p++) begin
        snap_d[p*IN_WORDS*16 +: IN_WIDTH] = probes_in[p*IN_WIDTH +: IN_WIDTH];
      end
    end
    if (commit) begin
      for (int i = 0; i < N_OUT; i++) begin
        out_d[i*OUT_WIDTH +: OUT_WIDTH] = stg_q[i*OUT_WORDS*16 +: OUT_WIDTH];
      end
      pending_d = 1'b0;
    end
    for (int w = 0; w < STG_WORDS; w++) begin
      if (wr_hit && (off17 == 17'(STG_OFF + w))) begin
        for (int j = 0; j < 16; j++) begin
          stg_d[w*16 + j] = (((w % OUT_WORDS) * 16 + j) < OUT_WIDTH) ? bus.wdata_i[j] : 1'b0;
        end
        pending_d = 1'b1;
      end
    end
  end

  // Register read mux, zero-extended to the bus width.
  always_comb begin
    rd_word = '0;
    if (off17 == 17'(CTRL_OFF)) begin
      rd_word[PENDING_BIT] = pending_q;
    end
    if (off17 == 17'(CHANGE_OFF)) begin
      rd_word[N_IN-1:0] = change_flags;
    end
    for (int w = 0; w < SNAP_WORDS; w++) begin
      if (off17 == 17'(FIRST_SNAP_OFF + w)) begin
        rd_word = snap_q[w*16 +: 16];
      end
    end
    for (int w = 0; w < STG_WORDS; w++) begin
      if (off17 == 17'(STG_OFF + w)) begin
        rd_word = stg_q[w*16 +: 16];
      end
    end
  end

  // Downstream bus: straight pass-through, read data replaced on a register hit.
  always_comb begin
    addr_o_d  = bus.addr_i;
    wdata_o_d = bus.wdata_i;
    rw_o_d    = bus.rw_i;
    valid_o_d = bus.valid_i;
    rdata_o_d = rd_hit ? rd_word : bus.rdata_i;
  end

  // All state and registered bus outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q    <= '0;
      stg_q     <= '0;
      out_q     <= '0;
      pending_q <= 1'b0;
      addr_o_q  <= '0;
      wdata_o_q <= '0;
      rdata_o_q <= '0;
      rw_o_q    <= 1'b0;
      valid_o_q <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      stg_q     <= stg_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      addr_o_q  <= addr_o_d;
      wdata_o_q <= wdata_o_d;
      rdata_o_q <= rdata_o_d;
      rw_o_q    <= rw_o_d;
      valid_o_q <= valid_o_d;
    end
  end

  assign probes_out  = out_q;
  assign bus.addr_o  = addr_o_q;
  assign bus.wdata_o = wdata_o_q;
  assign bus.rdata_o = rdata_o_q;
  assign bus.rw_o    = rw_o_q;
  assign bus.valid_o = valid_o_q;

endmodule

// File: tb/tb_probe_bank.sv
// Directed bench for probe_bank with default parameters
// (snapshot words at +2..+9, staging at +10..+11).
module tb_probe_bank;

  logic        clk;
  logic        rst;
  logic [79:0] probes_in;
  logic [15:0] probes_out;

  int n_cmp;
  int n_err;

  probe_bank_if bus_if ();

  probe_bank dut (
    .clk        (clk),
    .rst        (rst),
    .probes_in  (probes_in),
    .probes_out (probes_out),
    .bus        (bus_if)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one transaction on the falling edge.
  task automatic start(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] rdi);
    @(negedge clk);
    bus_if.rw_i    = rw;
    bus_if.addr_i  = a;
    bus_if.wdata_i = wd;
    bus_if.rdata_i = rdi;
    bus_if.valid_i = 1'b1;
  endtask

  // Let the transaction take effect; outputs are sampled just after the edge.
  task automatic finish();
    @(posedge clk);
    #1;
    bus_if.valid_i = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] wd);
    start(1'b1, a, wd, 16'h0000);
    finish();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    start(1'b0, a, 16'h0000, 16'hDEAD);
    finish();
    chk(tag, {16'h0, bus_if.rdata_o}, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset with busy-looking inputs; every output must sit at zero.
    rst            = 1'b1;
    probes_in      = '1;
    bus_if.valid_i = 1'b1;
    bus_if.rw_i    = 1'b0;
    bus_if.addr_i  = 16'h0005;
    bus_if.wdata_i = 16'hFFFF;
    bus_if.rdata_i = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_probes_out", {16'h0, probes_out}, 32'h0);
    chk("rst_rdata_o", {16'h0, bus_if.rdata_o}, 32'h0);
    chk("rst_addr_o", {16'h0, bus_if.addr_o}, 32'h0);
    chk("rst_wdata_o", {16'h0, bus_if.wdata_o}, 32'h0);
    chk("rst_valid_o", {31'h0, bus_if.valid_o}, 32'h0);
    @(negedge clk);
    rst            = 1'b0;
    bus_if.valid_i = 1'b0;
    bus_if.addr_i  = 16'h0;
    bus_if.wdata_i = 16'h0;
    bus_if.rdata_i = 16'h0;

    // All-ones probes against a zero prev register: every flag set.
    rd_chk("change_after_rst", 16'd1, 32'h000F);

    // Snapshot probe1 = 0xABCDE.
    @(negedge clk);
    probes_in[20 +: 20] = 20'hABCDE;
    wr(16'd0, 16'h0001);
    rd_chk("snap_p1_w0", 16'd4, 32'hBCDE);
    rd_chk("snap_p1_w1", 16'd5, 32'h000A);
    rd_chk("snap_p0_w0", 16'd2, 32'hFFFF);
    rd_chk("snap_p0_w1", 16'd3, 32'h000F);
    rd_chk("change_after_snap", 16'd1, 32'h0000);

    // A register write still forwards upstream read data and the bus fields.
    start(1'b1, 16'd0, 16'h0000, 16'h5A5A);
    finish();
    chk("wr_rdata_pass", {16'h0, bus_if.rdata_o}, 32'h5A5A);
    chk("wr_addr_o", {16'h0, bus_if.addr_o}, 32'h0);
    chk("wr_rw_o", {31'h0, bus_if.rw_o}, 32'h1);

    // Stage, check pending, then commit.
    wr(16'd10, 16'h01FF);
    wr(16'd11, 16'h0055);
    chk("out_before_commit", {16'h0, probes_out}, 32'h0);
    rd_chk("ctrl_pending", 16'd0, 32'h0002);
    rd_chk("stg0_masked", 16'd10, 32'h00FF);
    wr(16'd0, 16'h0002);
    chk("out_after_commit", {16'h0, probes_out}, 32'h55FF);
    rd_chk("ctrl_after_commit", 16'd0, 32'h0000);

    // Probe2 changes in the same cycle SNAP is presented.
    start(1'b1, 16'd0, 16'h0001, 16'h0000);
    probes_in[40 +: 20] = 20'h12345;
    finish();
    rd_chk("snap_p2_w0", 16'd6, 32'h2345);
    rd_chk("snap_p2_w1", 16'd7, 32'h0001);
    rd_chk("snap_p1_kept", 16'd4, 32'hBCDE);
    rd_chk("change_p2_set_wins", 16'd1, 32'h0004);

    // Just past the map: pure pass-through.
    start(1'b0, 16'd12, 16'h0000, 16'h1234);
    finish();
    chk("oor_rdata", {16'h0, bus_if.rdata_o}, 32'h1234);
    chk("oor_addr_o", {16'h0, bus_if.addr_o}, 32'h000C);
    chk("oor_valid_o", {31'h0, bus_if.valid_o}, 32'h1);
    chk("oor_rw_o", {31'h0, bus_if.rw_o}, 32'h0);

    // Stage a new value, then an unqualified SNAP|COMMIT write to CTRL.
    wr(16'd10, 16'h00AA);
    @(negedge clk);
    bus_if.valid_i = 1'b0;
    bus_if.rw_i    = 1'b1;
    bus_if.addr_i  = 16'd0;
    bus_if.wdata_i = 16'h0003;
    bus_if.rdata_i = 16'h7777;
    @(posedge clk);
    #1;
    chk("novalid_rdata", {16'h0, bus_if.rdata_o}, 32'h7777);
    chk("novalid_valid_o", {31'h0, bus_if.valid_o}, 32'h0);
    chk("novalid_out_held", {16'h0, probes_out}, 32'h55FF);
    rd_chk("novalid_pending", 16'd0, 32'h0002);
    rd_chk("novalid_change", 16'd1, 32'h0004);
    wr(16'd12, 16'hFFFF);
    rd_chk("oor_write_ignored", 16'd11, 32'h0055);

    // Reset lands in the middle of a staging write, before any commit.
    start(1'b1, 16'd11, 16'h00CC, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out", {16'h0, probes_out}, 32'h0);
    chk("async_rst_valid_o", {31'h0, bus_if.valid_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst            = 1'b0;
    bus_if.valid_i = 1'b0;
    rd_chk("ctrl_after_rst2", 16'd0, 32'h0000);
    rd_chk("stg0_after_rst2", 16'd10, 32'h0000);
    rd_chk("stg1_after_rst2", 16'd11, 32'h0000);
    chk("out_after_rst2", {16'h0, probes_out}, 32'h0);
    rd_chk("change_after_rst2", 16'd1, 32'h000F);
    rd_chk("snap_after_rst2", 16'd4, 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
